// File: rtl/com_debounce.sv
// com_debounce: per-channel synchroniser and consecutive-sample debounce with rise/fall strobes
module com_debounce #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] DEFAULT = '1,
  parameter int DEPTH = 5,
  parameter int DIV = 1,
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic aclr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic tick
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] s;
  logic [PW-1:0] pc;
  logic [CW-1:0] cnt [WIDTH];
  logic wrap;
  if (WIDTH < 1 || WIDTH > 32 || DEPTH < 1 || DEPTH > 255 || DIV < 1 || DIV > 65535 || SYNC < 0 || SYNC > 3) begin : g_bad
    $error("com_debounce: illegal parameter value");
  end
  if (SYNC == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    localparam int SW = SYNC * WIDTH;
    logic [SW-1:0] sr;
    always_ff @(posedge clk or posedge aclr)
      if (aclr) sr <= {SYNC{DEFAULT}};
      else sr <= SW'({sr, in});
    assign s = sr[SW-1 -: WIDTH];
  end
  assign wrap = pc == PW'(DIV - 1);
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      pc <= '0;
      tick <= 1'b0;
    end else begin
      pc <= wrap ? '0 : pc + 1'b1;
      tick <= wrap;
    end
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      out <= DEFAULT;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      if (wrap)
        for (int i = 0; i < WIDTH; i++)
          if (s[i] == out[i]) cnt[i] <= '0;
          else if (cnt[i] == CW'(DEPTH - 1)) begin
            out[i] <= s[i];
            cnt[i] <= '0;
            rise[i] <= s[i];
            fall[i] <= ~s[i];
          end else cnt[i] <= cnt[i] + 1'b1;
    end
endmodule

// File: tb/tb_com_debounce.sv
// tb_com_debounce: scoreboard bench for default and DIV=4 debounce instances
module tb_com_debounce;
  logic clk = 1'b0;
  logic aclr = 1'b1;
  logic [15:0] in0 = '1, in1 = '1;
  logic [15:0] out0, rise0, fall0, out1, rise1, fall1;
  logic tick0, tick1;
  int cyc = 0, n_tot = 0, n_pass = 0;
  typedef struct { int c; logic [15:0] o, r, f; } exp_t;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  com_debounce u0 (.clk(clk), .aclr(aclr), .in(in0), .out(out0), .rise(rise0), .fall(fall0), .tick(tick0));
  com_debounce #(.DIV(4)) u1 (.clk(clk), .aclr(aclr), .in(in1), .out(out1), .rise(rise1), .fall(fall1), .tick(tick1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask
  task automatic mon(input int k, input logic [15:0] o, input logic [15:0] r, input logic [15:0] f);
    exp_t e;
    if (k == 0 && q0.size() == 0 || k == 1 && q1.size() == 0) begin
      chk($sformatf("u%0d unexpected strobe", k), {r, f}, 32'h0);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("u%0d strobe cycle", k), cyc, e.c);
    chk($sformatf("u%0d out", k), o, e.o);
    chk($sformatf("u%0d rise", k), r, e.r);
    chk($sformatf("u%0d fall", k), f, e.f);
  endtask
  always @(negedge clk)
    if (!aclr) begin
      if ((rise0 | fall0) != 0) mon(0, out0, rise0, fall0);
      if ((rise1 | fall1) != 0) mon(1, out1, rise1, fall1);
    end
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int k, input int c, input logic [15:0] o, input logic [15:0] r, input logic [15:0] f);
    if (k == 0) q0.push_back('{c, o, r, f});
    else q1.push_back('{c, o, r, f});
  endtask
  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end
  initial begin
    int c, r;
    w(3);
    chk("reset out0", out0, 16'hFFFF);
    chk("reset strobes0", {rise0, fall0}, 32'h0);
    chk("reset tick0", tick0, 0);
    chk("reset out1", out1, 16'hFFFF);
    chk("reset tick1", tick1, 0);
    aclr = 1'b0;
    r = cyc;
    for (int k = 1; k <= 12; k++) begin
      w(1);
      chk("tick0", tick0, 1);
      chk("tick1", tick1, (k % 4 == 0) ? 1 : 0);
    end
    in1 = 16'h7FFF;
    push(1, r + 32, 16'h7FFF, 16'h0, 16'h8000);
    w(19);
    chk("div4 out before", out1, 16'hFFFF);
    w(1);
    chk("div4 out fall", out1, 16'h7FFF);
    chk("div4 tick at fall", tick1, 1);
    in1 = 16'hFFFF;
    push(1, r + 52, 16'hFFFF, 16'h8000, 16'h0);
    w(19);
    chk("div4 out before rise", out1, 16'h7FFF);
    w(1);
    chk("div4 out rise", out1, 16'hFFFF);
    c = cyc;
    in0 = 16'hFFFE;
    push(0, c + 7, 16'hFFFE, 16'h0, 16'h0001);
    w(6);
    chk("held out edge6", out0, 16'hFFFF);
    w(1);
    chk("held out edge7", out0, 16'hFFFE);
    c = cyc;
    in0 = 16'hFFFF;
    push(0, c + 7, 16'hFFFF, 16'h0001, 16'h0);
    w(6);
    chk("return out edge6", out0, 16'hFFFE);
    w(1);
    chk("return out edge7", out0, 16'hFFFF);
    in0 = 16'hFFF7;
    w(4);
    in0 = 16'hFFFF;
    w(10);
    chk("glitch4 out", out0, 16'hFFFF);
    c = cyc;
    in0 = 16'hFFF7;
    push(0, c + 7, 16'hFFF7, 16'h0, 16'h0008);
    w(5);
    in0 = 16'hFFFF;
    push(0, c + 12, 16'hFFFF, 16'h0008, 16'h0);
    w(2);
    chk("pulse5 out", out0, 16'hFFF7);
    w(5);
    chk("pulse5 recover", out0, 16'hFFFF);
    for (int k = 0; k < 100; k++) begin
      in0[5] = ~in0[5];
      w(1);
      chk("chatter out5", out0[5], 1);
    end
    in0 = 16'hFFFF;
    w(10);
    chk("chatter out", out0, 16'hFFFF);
    in0 = 16'h0000;
    w(5);
    aclr = 1'b1;
    #1;
    chk("midcount reset out", out0, 16'hFFFF);
    chk("midcount reset strobes", {rise0, fall0}, 32'h0);
    chk("midcount reset tick", tick0, 0);
    w(2);
    aclr = 1'b0;
    c = cyc;
    push(0, c + 7, 16'h0000, 16'h0, 16'hFFFF);
    w(6);
    chk("requalify edge6", out0, 16'hFFFF);
    w(1);
    chk("requalify edge7", out0, 16'h0000);
    c = cyc;
    in0 = 16'hFFFF;
    push(0, c + 7, 16'hFFFF, 16'hFFFF, 16'h0);
    w(7);
    chk("all rise out", out0, 16'hFFFF);
    w(3);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/com_debounce.md
# com_debounce

Parametrised per-channel debounce filter for discrete command inputs, successor to the fixed 16-bit, 5-stage command input filter. Each channel passes through a metastability synchroniser and a consecutive-sample counter. The output changes state only after the input has disagreed with it for DEPTH consecutive sample ticks. The block also emits one-cycle rise/fall strobes and sits between the command input pins and the command decoding logic.

## Interface

- WIDTH, 16: number of channels (1..32).
- DEFAULT, all ones (WIDTH bits): state of synchroniser flops and `out` after reset; inactive command level.
- DEPTH, 5: consecutive disagreeing samples required to change `out` (1..255).
- DIV, 1: sample tick period in clk cycles (1..65535).
- SYNC, 2: synchroniser stages (0..3); 0 samples `in` directly.

- clk  in  1  clock; all logic on rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- in  in  WIDTH  raw command inputs, asynchronous to clk.
- out  out  WIDTH  debounced command state; reset DEFAULT.
- rise  out  WIDTH  one-cycle strobe, out[i] went 0->1; reset 0.
- fall  out  WIDTH  one-cycle strobe, out[i] went 1->0; reset 0.
- tick  out  1  sample strobe, high one cycle per DIV cycles; reset 0.

## Operation

- Illegal parameter values cause an elaboration error.
- Synchroniser: SYNC-flop chain per channel; every flop resets to DEFAULT. The chain output is `s`.
- Prescaler: counter `pc` in 0..DIV-1, reset 0.
  - Each cycle: if `pc`==DIV-1, then `pc`<=0 and `tick`<=1; else `pc`<=`pc`+1 and `tick`<=0.
  - `tick` is registered. With DIV=1, `tick` is high every cycle from the first edge after reset release.
- Per-channel counter `cnt[i]`: width clog2(DEPTH+1), reset 0. It updates only on cycles where the prescaler wraps (same edge that sets `tick`).
  - `s[i]`==`out[i]`: `cnt[i]`<=0.
  - `s[i]`!=`out[i]` and `cnt[i]`==DEPTH-1: `out[i]`<=`s[i]`, `cnt[i]`<=0, matching strobe <=1.
  - Otherwise: `cnt[i]`<=`cnt[i]`+1.
- Any single agreeing sample discards the accumulated count; chatter never changes `out`.
- Strobes are registered with `out`: `rise[i]`/`fall[i]` are high exactly in the cycle `out[i]` first shows its new value. They are 0 in every other cycle, including non-tick cycles.
- At most one of `rise[i]`/`fall[i]` is high per cycle. Channels are fully independent, and any combination may switch on the same tick.

## Timing

- Latency (DIV=1): a stable change on `in[i]` set up before edge 0 appears on `out[i]` after edge SYNC+DEPTH.
  - Defaults: edge 7.
  - SYNC=0, DEPTH=1: edge 1.
- DIV>1: `out[i]` changes on the DEPTH-th tick at which `s[i]` disagrees with it.
  - Worst-case latency: SYNC + DEPTH·DIV cycles.
- Minimum accepted pulse: DEPTH consecutive ticks. Shorter pulses produce no `out` change and no strobe.
- Asserting aclr at any time, including mid-count, immediately forces:
  - `out`=DEFAULT, synchroniser=DEFAULT;
  - `cnt`=0, `pc`=0;
  - `rise`=`fall`=`tick`=0.
- No strobe is generated by reset itself.
- After aclr release, a full DEPTH-tick qualification is required again.
- Counter saturation cannot occur: `cnt` never exceeds DEPTH-1.

## Test plan

- Reset (defaults): pulse aclr with `in`=16'hFFFF -> `out`=16'hFFFF, `rise`=`fall`=0; `tick`=1 every cycle from first edge after release.
- Held change: `in`=16'hFFFE held -> `out`=16'hFFFE after edge 7, `fall`=16'h0001 for exactly that cycle, no other strobes. Returning `in` to 16'hFFFF -> `rise`=16'h0001 after 7 more edges.
- Glitch rejection: `in[3]` low for 4 cycles -> `out` stays 16'hFFFF, no strobes. Low for 5 cycles -> `out`=16'hFFF7 and `fall[3]` pulses.
- Chatter: `in[5]` toggles every cycle for 100 cycles -> `out[5]` stays 1, `rise`/`fall` always 0.
- Prescaled (DIV=4): `tick` high on cycles 4, 8, 12… after release. `in`=16'h7FFF held -> `out[15]` falls on the 5th tick after `s[15]` changes, and `fall[15]` coincides with that tick cycle.
- Reset mid-count: `in`=16'h0000 held, aclr asserted when `cnt`=3 -> `out`=16'hFFFF immediately, no strobes. After release, `out`=16'h0000 only 7 edges later.
